// File: rtl/connect4_move_sequencer_if.sv
// Signal bundle between the Connect-4 move sequencer and its surroundings:
// input controller, board memory, win checker and status display.
// The master side is the environment. The slave side is the sequencer.
interface connect4_move_sequencer_if;
    logic [2:0] column_select;
    logic       drop_en;
    logic       new_game;
    logic       board_we;
    logic [2:0] board_col;
    logic [2:0] board_row;
    logic       board_player;
    logic       board_clr;
    logic       chk_start;
    logic       chk_done;
    logic       chk_win;
    logic       current_player;
    logic       move_reject;
    logic       game_over;
    logic [1:0] winner;
    logic       anim_valid;
    logic [2:0] anim_row;

    modport master (
        output column_select, drop_en, new_game, chk_done, chk_win,
        input  board_we, board_col, board_row, board_player, board_clr,
               chk_start, current_player, move_reject, game_over, winner,
               anim_valid, anim_row
    );

    modport slave (
        input  column_select, drop_en, new_game, chk_done, chk_win,
        output board_we, board_col, board_row, board_player, board_clr,
               chk_start, current_player, move_reject, game_over, winner,
               anim_valid, anim_row
    );
endinterface

// File: rtl/connect4_move_sequencer.sv
// Connect-4 game-control FSM.
// Each drop is validated against per-column fill counters, and the landing row
// is computed from the target column's counter. The sequencer then issues one
// board write and a start/done handshake with the external win checker.
// It alternates players and detects win, draw and game-over.
// Optional falling-disc animation: define CONNECT4_DROP_ANIM_EN.
module connect4_move_sequencer #(
    parameter int COLS       = 7,
    parameter int ROWS       = 6,
    parameter int ANIM_TICKS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    connect4_move_sequencer_if.slave bus
);
    localparam int HW    = $clog2(ROWS + 1);
    localparam int CELLS = ROWS * COLS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VALIDATE,
`ifdef CONNECT4_DROP_ANIM_EN
        S_FALL,
`endif
        S_WRITE,
        S_CHECK_REQ,
        S_CHECK_WAIT,
        S_OVER
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      col_q;
    logic [2:0]      row_q;
    logic [HW-1:0]   height_q [COLS];
    logic [5:0]      move_cnt_q;
    logic            player_q;
    logic [1:0]      winner_q;
    logic            game_over_q;
    logic            we_q, clr_q, start_q, rej_q;
    logic            we_d, clr_d, start_d, rej_d;
    logic [2:0]      board_col_q, board_row_q;
    logic            board_player_q;

    logic            col_ok;
    logic [2:0]      col_idx;
    logic            legal;
    logic            full;
    logic [2:0]      wr_row;

    // An out-of-range column never indexes the height array; it is rejected instead.
    assign col_ok  = 32'(col_q) < COLS;
    assign col_idx = col_ok ? col_q : 3'd0;
    assign legal   = col_ok && (32'(height_q[col_idx]) < ROWS);
    assign full    = 32'(move_cnt_q) == CELLS;
    // Without animation the write follows VALIDATE directly, before row_q is loaded.
    assign wr_row  = (state_q == S_VALIDATE) ? 3'(height_q[col_idx]) : row_q;

`ifdef CONNECT4_DROP_ANIM_EN
    localparam int TW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;

    logic [TW-1:0] tick_q;
    logic [2:0]    anim_row_q;
    logic          anim_valid_q;
    logic          tick_last;
    logic          fall_done;

    assign tick_last = 32'(tick_q) == (ANIM_TICKS - 1);
    assign fall_done = tick_last && (anim_row_q == row_q);
`endif

    // Next-state and strobe decode; new_game overrides everything, including a pending drop.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        clr_d   = 1'b0;
        start_d = 1'b0;
        rej_d   = 1'b0;
        if (bus.new_game) begin
            state_d = S_IDLE;
            clr_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.drop_en) state_d = S_VALIDATE;
                end
                S_VALIDATE: begin
                    if (!legal) begin
                        rej_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
`ifdef CONNECT4_DROP_ANIM_EN
                        state_d = S_FALL;
`else
                        state_d = S_WRITE;
                        we_d    = 1'b1;
`endif
                    end
                end
`ifdef CONNECT4_DROP_ANIM_EN
                S_FALL: begin
                    if (fall_done) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                    end
                end
`endif
                S_WRITE: begin
                    state_d = S_CHECK_REQ;
                    start_d = 1'b1;
                end
                S_CHECK_REQ: begin
                    state_d = S_CHECK_WAIT;
                end
                S_CHECK_WAIT: begin
                    if (bus.chk_done) state_d = (bus.chk_win || full) ? S_OVER : S_IDLE;
                end
                S_OVER: begin
                    state_d = S_OVER;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Registered strobes and board-write bus, so every output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q           <= 1'b0;
            clr_q          <= 1'b0;
            start_q        <= 1'b0;
            rej_q          <= 1'b0;
            game_over_q    <= 1'b0;
            board_col_q    <= 3'd0;
            board_row_q    <= 3'd0;
            board_player_q <= 1'b0;
        end else begin
            we_q           <= we_d;
            clr_q          <= clr_d;
            start_q        <= start_d;
            rej_q          <= rej_d;
            game_over_q    <= (state_d == S_OVER);
            board_col_q    <= we_d ? col_q  : 3'd0;
            board_row_q    <= we_d ? wr_row : 3'd0;
            board_player_q <= we_d & player_q;
        end
    end

    // Game state: latched column, landing row, column heights, move count, turn and result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= 3'd0;
            row_q      <= 3'd0;
            move_cnt_q <= 6'd0;
            player_q   <= 1'b0;
            winner_q   <= 2'b00;
            for (int i = 0; i < COLS; i++) height_q[i] <= '0;
        end else if (bus.new_game) begin
            move_cnt_q <= 6'd0;
            player_q   <= 1'b0;
            winner_q   <= 2'b00;
            for (int i = 0; i < COLS; i++) height_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.drop_en) col_q <= bus.column_select;
                end
                S_VALIDATE: begin
                    if (legal) row_q <= wr_row;
                end
                S_WRITE: begin
                    height_q[col_idx] <= height_q[col_idx] + HW'(1);
                    move_cnt_q        <= move_cnt_q + 6'd1;
                end
                S_CHECK_WAIT: begin
                    if (bus.chk_done) begin
                        if (bus.chk_win) winner_q <= player_q ? 2'b10 : 2'b01;
                        else if (full)   winner_q <= 2'b11;
                        else             player_q <= ~player_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CONNECT4_DROP_ANIM_EN
    // Fall animation: step down one row every ANIM_TICKS cycles, then hold on the landing row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q       <= '0;
            anim_row_q   <= 3'd0;
            anim_valid_q <= 1'b0;
        end else if (bus.new_game) begin
            tick_q       <= '0;
            anim_row_q   <= 3'd0;
            anim_valid_q <= 1'b0;
        end else if (state_q == S_VALIDATE && legal) begin
            tick_q       <= '0;
            anim_row_q   <= 3'(ROWS - 1);
            anim_valid_q <= 1'b1;
        end else if (state_q == S_FALL) begin
            if (tick_last) begin
                tick_q <= '0;
                if (anim_row_q == row_q) begin
                    anim_row_q   <= 3'd0;
                    anim_valid_q <= 1'b0;
                end else begin
                    anim_row_q <= anim_row_q - 3'd1;
                end
            end else begin
                tick_q <= tick_q + TW'(1);
            end
        end
    end

    assign bus.anim_valid = anim_valid_q;
    assign bus.anim_row   = anim_row_q;
`else
    assign bus.anim_valid = 1'b0;
    assign bus.anim_row   = 3'd0;
`endif

    assign bus.board_we       = we_q;
    assign bus.board_col      = board_col_q;
    assign bus.board_row      = board_row_q;
    assign bus.board_player   = board_player_q;
    assign bus.board_clr      = clr_q;
    assign bus.chk_start      = start_q;
    assign bus.current_player = player_q;
    assign bus.move_reject    = rej_q;
    assign bus.game_over      = game_over_q;
    assign bus.winner         = winner_q;
endmodule

// File: tb/tb_connect4_move_sequencer.sv
// Self-checking bench for connect4_move_sequencer.
// A game-level model (column heights, move count, turn, result) predicts every
// board write, rejection and game outcome. Directed scenarios are followed by
// randomized play.
module tb_connect4_move_sequencer;
    localparam int COLS       = 7;
    localparam int ROWS       = 6;
    localparam int ANIM_TICKS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    connect4_move_sequencer_if bus();

    connect4_move_sequencer #(
        .COLS(COLS), .ROWS(ROWS), .ANIM_TICKS(ANIM_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Game-level reference model.
    int m_height [COLS];
    int m_moves;
    int m_player;
    int m_winner;
    int m_over;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < COLS; i++) m_height[i] = 0;
        m_moves  = 0;
        m_player = 0;
        m_winner = 0;
        m_over   = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet(input string tag);
        check_eq({tag, "_we"},    bus.board_we,    0);
        check_eq({tag, "_rej"},   bus.move_reject, 0);
        check_eq({tag, "_start"}, bus.chk_start,   0);
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, "_player"}, bus.current_player, m_player);
        check_eq({tag, "_winner"}, bus.winner,         m_winner);
        check_eq({tag, "_over"},   bus.game_over,      m_over);
    endtask

    task automatic new_game_pulse();
        bus.new_game = 1'b1;
        step();
        bus.new_game = 1'b0;
        model_reset();
        check_eq("ng_clr", bus.board_clr, 1);
        check_status("ng");
        quiet("ng");
        step();
        check_eq("ng_clr_width", bus.board_clr, 0);
    endtask

    // kind: 0 normal completion, 1 new_game while waiting, 2 reset while waiting.
    task automatic do_move(input int col, input bit win, input int delay,
                           input bit stray, input int kind);
        bit legal;
        int row;
        legal = 0;
        row   = 0;
        if (col < COLS) begin
            legal = m_height[col] < ROWS;
            row   = m_height[col];
        end
        bus.column_select = 3'(col);
        bus.drop_en       = 1'b1;
        step();
        bus.drop_en = 1'b0;
        quiet("validate");
        if (!legal) begin
            step();
            check_eq("rej_pulse", bus.move_reject, 1);
            check_eq("rej_no_we", bus.board_we, 0);
            step();
            check_eq("rej_width", bus.move_reject, 0);
            check_eq("rej_no_start", bus.chk_start, 0);
            check_status("rej");
            return;
        end
`ifdef CONNECT4_DROP_ANIM_EN
        for (int k = 0; k < (ROWS - row) * ANIM_TICKS; k++) begin
            step();
            check_eq("anim_valid", bus.anim_valid, 1);
            check_eq("anim_row", bus.anim_row, ROWS - 1 - k / ANIM_TICKS);
            quiet("fall");
        end
`endif
        step();
        check_eq("we", bus.board_we, 1);
        check_eq("we_col", bus.board_col, col);
        check_eq("we_row", bus.board_row, row);
        check_eq("we_player", bus.board_player, m_player);
        check_eq("we_anim_off", bus.anim_valid, 0);
        m_height[col]++;
        m_moves++;
        step();
        check_eq("start", bus.chk_start, 1);
        check_eq("we_width", bus.board_we, 0);
        step();
        check_eq("start_width", bus.chk_start, 0);
        for (int k = 0; k < delay; k++) begin
            if (stray && k == 0) begin
                bus.column_select = 3'($urandom_range(0, 6));
                bus.drop_en       = 1'b1;
            end
            step();
            bus.drop_en = 1'b0;
            quiet("wait");
            check_status("wait");
        end
        if (kind == 1) begin
            new_game_pulse();
            bus.chk_done = 1'b1;
            bus.chk_win  = 1'b1;
            step();
            bus.chk_done = 1'b0;
            bus.chk_win  = 1'b0;
            check_status("late_done");
            quiet("late_done");
            return;
        end
        if (kind == 2) begin
            #2 rst = 1'b1;
            #1;
            check_eq("rst_outputs",
                     {bus.board_we, bus.board_col, bus.board_row, bus.board_player,
                      bus.board_clr, bus.chk_start, bus.current_player, bus.move_reject,
                      bus.game_over, bus.winner, bus.anim_valid, bus.anim_row}, 0);
            step();
            rst = 1'b0;
            model_reset();
            return;
        end
        bus.chk_done = 1'b1;
        bus.chk_win  = win;
        step();
        bus.chk_done = 1'b0;
        bus.chk_win  = 1'b0;
        if (win) begin
            m_winner = (m_player == 1) ? 2 : 1;
            m_over   = 1;
        end else if (m_moves == ROWS * COLS) begin
            m_winner = 3;
            m_over   = 1;
        end else begin
            m_player = 1 - m_player;
        end
        check_status("done");
    endtask

    task automatic over_drop();
        bus.column_select = 3'($urandom_range(0, 6));
        bus.drop_en       = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            bus.drop_en = 1'b0;
            quiet("over");
            check_status("over");
        end
    endtask

    task automatic idle_done_probe();
        bus.chk_done = 1'b1;
        bus.chk_win  = 1'b1;
        step();
        bus.chk_done = 1'b0;
        bus.chk_win  = 1'b0;
        check_status("idle_done");
        quiet("idle_done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus.column_select = 3'd0;
        bus.drop_en       = 1'b0;
        bus.new_game      = 1'b0;
        bus.chk_done      = 1'b0;
        bus.chk_win       = 1'b0;
        model_reset();
        step();
        step();
        check_eq("reset_outputs",
                 {bus.board_we, bus.board_col, bus.board_row, bus.board_player,
                  bus.board_clr, bus.chk_start, bus.current_player, bus.move_reject,
                  bus.game_over, bus.winner, bus.anim_valid, bus.anim_row}, 0);
        rst = 1'b0;
        step();

        // First move into column 3, then a stray checker response while idle.
        do_move(3, 1'b0, 2, 1'b0, 0);
        idle_done_probe();

        // Column 0 filled, seventh drop rejected; then an out-of-range column.
        new_game_pulse();
        for (int i = 0; i < 7; i++) do_move(0, 1'b0, 1, 1'b0, 0);
        do_move(7, 1'b0, 0, 1'b0, 0);
        do_move(1, 1'b0, 0, 1'b0, 0);

        // Second player wins; the game is frozen until new_game.
        new_game_pulse();
        do_move(2, 1'b0, 0, 1'b0, 0);
        do_move(4, 1'b1, 0, 1'b0, 0);
        over_drop();
        new_game_pulse();

        // Full board without a win is a draw.
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                do_move(c, 1'b0, 0, 1'b0, 0);
        over_drop();
        new_game_pulse();

        // Long wait with a stray drop, then reset mid-wait; the column restarts at row 0.
        do_move(5, 1'b0, 20, 1'b1, 2);
        do_move(5, 1'b0, 0, 1'b0, 0);
        // new_game abandons a pending check.
        do_move(1, 1'b0, 3, 1'b0, 1);

        // Randomized play.
        for (int it = 0; it < 250; it++) begin
            if (m_over != 0) begin
                over_drop();
                new_game_pulse();
            end else if ($urandom_range(0, 15) == 0) begin
                idle_done_probe();
            end else begin
                do_move($urandom_range(0, 7), $urandom_range(0, 29) == 0,
                        $urandom_range(0, 4), $urandom_range(0, 3) == 0,
                        ($urandom_range(0, 19) == 0) ? 1 : 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/connect4_move_sequencer.md
Name: connect4_move_sequencer

Overview:
- Game-control FSM between the input controller (column select + 1-cycle drop pulse) and the board memory / win checker.
- Validates each drop against per-column fill counters and computes the landing row.
- Issues one board write, then runs a start/done handshake with the external win checker.
- Alternates players and detects win, draw and game-over.

Parameters:
COLS, 7, number of board columns
ROWS, 6, number of board rows (row 0 = bottom)
ANIM_TICKS, 4, clock cycles per row step during the fall animation (used only with DROP_ANIM_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
column_select  input  3  requested column
drop_en  input  1  1-cycle drop request pulse
new_game  input  1  synchronous restart request
board_we  output  1  1-cycle board write strobe
board_col  output  3  write column, valid with board_we
board_row  output  3  write row, valid with board_we
board_player  output  1  disc owner, valid with board_we (0 = P1, 1 = P2)
board_clr  output  1  1-cycle board-clear pulse
chk_start  output  1  1-cycle win-check request
chk_done  input  1  win-check complete
chk_win  input  1  last move wins; valid with chk_done
current_player  output  1  player to move
move_reject  output  1  1-cycle pulse on an illegal drop
game_over  output  1  game finished
winner  output  2  00 none, 01 P1, 10 P2, 11 draw
anim_valid  output  1  falling disc being shown
anim_row  output  3  row of the falling disc

Behaviour:
- Reset (async, rst=1), all outputs 0:
  - state IDLE, all column heights 0, move counter 0, current_player 0, winner 00, game_over 0.
- Storage:
  - One height counter per column, 0..ROWS.
  - Move counter, 0..ROWS*COLS, 6 bits.
- FSM states: IDLE, VALIDATE, [FALL], WRITE, CHECK_REQ, CHECK_WAIT, OVER.
- IDLE:
  - drop_en=1 latches column_select into col_q; go to VALIDATE.
- VALIDATE:
  - If col_q >= COLS or height[col_q] == ROWS: pulse move_reject, return to IDLE, player unchanged.
  - Otherwise set row_q = height[col_q] and go to WRITE.
- WRITE:
  - board_we=1 with board_col=col_q, board_row=row_q, board_player=current_player.
  - height[col_q] increments; move counter increments.
  - Go to CHECK_REQ.
- CHECK_REQ:
  - chk_start=1 for one cycle; go to CHECK_WAIT.
- CHECK_WAIT:
  - Waits indefinitely. chk_done is sampled only in this state; chk_done in any other state is ignored.
  - On chk_done with chk_win=1: winner = current_player ? 10 : 01; go to OVER.
  - Otherwise, if move counter == ROWS*COLS: winner=11; go to OVER.
  - Otherwise: toggle current_player; go to IDLE.
- OVER:
  - game_over=1.
  - drop_en ignored, no move_reject.
- Latency: drop_en sampled at cycle N gives board_we at N+2 and chk_start at N+3.
- drop_en in any state other than IDLE is dropped silently: no queuing, no move_reject.
- new_game (any state, including CHECK_WAIT and FALL):
  - Next cycle: state IDLE, heights and move counter 0, current_player 0, winner 00, game_over 0.
  - board_clr pulses for 1 cycle.
  - A pending check is abandoned; a late chk_done is ignored.
  - new_game wins over a simultaneous drop_en; the drop is lost.
- Outputs are registered; strobes (board_we, board_clr, chk_start, move_reject) are exactly one cycle wide.

Optional Feature:
- Macro: CONNECT4_DROP_ANIM_EN.
- When defined:
  - VALIDATE on a legal drop enters FALL instead of WRITE.
  - FALL drives anim_valid=1 with anim_row starting at ROWS-1.
  - anim_row decrements every ANIM_TICKS cycles until it equals row_q, holds there for ANIM_TICKS cycles, then the FSM goes to WRITE.
  - anim_valid=0 in WRITE.
  - Drop latency becomes 2 + (ROWS-row_q)*ANIM_TICKS cycles to board_we.
- When undefined:
  - FALL does not exist; anim_valid and anim_row are tied 0.
  - Latency is as stated in Behaviour.

Test Plan:
- Reset, column_select=3, drop_en pulse at cycle N -> board_we at N+2 with col 3, row 0, player 0; chk_start at N+3; chk_done=1, chk_win=0 -> current_player=1, IDLE.
- Six legal drops into column 0 (checker answers no-win), then a 7th drop on column 0 -> move_reject pulse, no board_we, no chk_start, current_player unchanged.
- column_select=7, drop_en -> move_reject pulse 2 cycles later; heights and move counter unchanged.
- Player 1 moves, then chk_done=1 with chk_win=1 -> winner=10, game_over=1; subsequent drop_en -> no response; new_game -> board_clr pulse, winner=00, game_over=0, current_player=0.
- Fill all 42 cells with chk_win=0 throughout -> after the 42nd chk_done, winner=11, game_over=1.
- In CHECK_WAIT, pulse drop_en -> ignored; hold chk_done low 20 cycles -> FSM stays in CHECK_WAIT; assert rst mid-wait -> all outputs 0 immediately, next drop writes row 0.
